yarvi_mem_bridge: RTL

//  Downstream of the execute stage: accepts ex_mem_* load/store requests and buffers them in a request FIFO.

---
 rtl/yarvi_mem_bridge_if.sv | 42 ++++
 rtl/yarvi_mem_bridge.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/yarvi_mem_bridge_if.sv
// Request-side and bus-side signal bundle for yarvi_mem_bridge.
// The bridge is the bus master; the slave modport is the execute stage plus memory view.
interface yarvi_mem_bridge_if;
    localparam int AW = 32;

    logic          valid;
    logic          writeenable;
    logic [AW-1:0] address;
    logic [63:0]   writedata;
    logic [1:0]    sizelg2;
    logic [4:0]    readtag;
    logic          readsignextend;

    logic          me_ready;
    logic          me_readdatavalid;
    logic [4:0]    me_readdatatag;
    logic [63:0]   me_readdata;
    logic          me_error;

    logic [AW-1:0] bus_address;
    logic          bus_read;
    logic          bus_write;
    logic [7:0]    bus_byteenable;
    logic [63:0]   bus_writedata;
    logic          bus_waitrequest;
    logic          bus_readdatavalid;
    logic [63:0]   bus_readdata;

    modport master (
        input  valid, writeenable, address, writedata, sizelg2, readtag, readsignextend,
        input  bus_waitrequest, bus_readdatavalid, bus_readdata,
        output me_ready, me_readdatavalid, me_readdatatag, me_readdata, me_error,
        output bus_address, bus_read, bus_write, bus_byteenable, bus_writedata
    );

    modport slave (
        output valid, writeenable, address, writedata, sizelg2, readtag, readsignextend,
        output bus_waitrequest, bus_readdatavalid, bus_readdata,
        input  me_ready, me_readdatavalid, me_readdatatag, me_readdata, me_error,
        input  bus_address, bus_read, bus_write, bus_byteenable, bus_writedata
    );
endinterface

// File: rtl/yarvi_mem_bridge.sv
// Load/store bridge: request FIFO -> in-order 64-bit bus commands, with an
// in-order read-tracking FIFO that aligns and extends returned load data.
//
// state | meaning
// IDLE  | no command on the bus
// CMD   | bus_read or bus_write asserted, held until waitrequest drops
module yarvi_mem_bridge #(
    parameter int REQ_DEPTH = 4,
    parameter int RD_DEPTH  = 4
) (
    input logic               clock,
    input logic               reset,
    yarvi_mem_bridge_if.master io
);
    localparam int AW  = 32;
    localparam int RQW = $clog2(REQ_DEPTH);
    localparam int RDW = $clog2(RD_DEPTH);

    typedef enum logic { S_IDLE, S_CMD } state_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
        logic [1:0]    size;
        logic [4:0]    tag;
        logic          sext;
    } req_t;

    typedef struct packed {
        logic [4:0] tag;
        logic [2:0] off;
        logic [1:0] size;
        logic       sext;
    } trk_t;

    req_t req_mem_q [REQ_DEPTH];
    trk_t trk_mem_q [RD_DEPTH];

    state_e        state_q, state_d;
    logic [RQW-1:0] req_wptr_q, req_wptr_d, req_rptr_q, req_rptr_d;
    logic [RQW:0]   req_count_q, req_count_d;
    logic [RDW-1:0] trk_wptr_q, trk_wptr_d, trk_rptr_q, trk_rptr_d;
    logic [RDW:0]   rd_count_q, rd_count_d;
    logic [AW-1:0]  bus_addr_q, bus_addr_d;
    logic           bus_read_q, bus_read_d, bus_write_q, bus_write_d;
    logic [7:0]     bus_be_q, bus_be_d;
    logic [63:0]    bus_wdata_q, bus_wdata_d;
    trk_t           cmd_trk_q, cmd_trk_d;
    logic           rdv_q, rdv_d, err_q, err_d;
    logic [4:0]     rtag_q, rtag_d;
    logic [63:0]    rdata_q, rdata_d;

    req_t        req_in, head;
    trk_t        ent;
    logic        req_push, cmd_done, trk_push, trk_pop, head_ok, issue, rd_room;
    logic [RDW+1:0] rd_next;
    logic [2:0]  amask, off;
    logic [7:0]  be_base;
    logic [AW-1:0] aligned;
    logic [63:0] shifted;

    // Request/track bookkeeping, command issue and load-return formatting
    always_comb begin
        req_in   = '{we: io.writeenable, addr: io.address, wdata: io.writedata,
                     size: io.sizelg2, tag: io.readtag, sext: io.readsignextend};
        head     = req_mem_q[req_rptr_q];
        ent      = trk_mem_q[trk_rptr_q];
        req_push = io.valid && (req_count_q != (RQW+1)'(REQ_DEPTH));
        cmd_done = (state_q == S_CMD) && !io.bus_waitrequest;
        trk_push = cmd_done && bus_read_q;
        trk_pop  = io.bus_readdatavalid && (rd_count_q != '0);
        // Count the read completing this cycle so a back-to-back load cannot overfill tracking
        rd_next  = (RDW+2)'(rd_count_q) + (RDW+2)'(trk_push);
        rd_room  = rd_next < (RDW+2)'(RD_DEPTH);
        head_ok  = (req_count_q != '0) && (head.we || rd_room);
        issue    = head_ok && ((state_q == S_IDLE) || cmd_done);

        case (head.size)
            2'd0:    begin amask = 3'b000; be_base = 8'h01; end
            2'd1:    begin amask = 3'b001; be_base = 8'h03; end
            2'd2:    begin amask = 3'b011; be_base = 8'h0F; end
            default: begin amask = 3'b111; be_base = 8'hFF; end
        endcase
        aligned = {head.addr[AW-1:3], head.addr[2:0] & ~amask};
        off     = aligned[2:0];

        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_read_d  = bus_read_q;
        bus_write_d = bus_write_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        cmd_trk_d   = cmd_trk_q;
        err_d       = err_q;

        if (issue) begin
            state_d     = S_CMD;
            bus_addr_d  = {aligned[AW-1:3], 3'b000};
            bus_read_d  = !head.we;
            bus_write_d = head.we;
            bus_be_d    = be_base << off;
            bus_wdata_d = head.wdata << {off, 3'b000};
            cmd_trk_d   = '{tag: head.tag, off: off, size: head.size, sext: head.sext};
            if ((head.addr[2:0] & amask) != 3'b000)
                err_d = 1'b1;
        end else if (cmd_done) begin
            state_d     = S_IDLE;
            bus_read_d  = 1'b0;
            bus_write_d = 1'b0;
        end

        if (io.bus_readdatavalid && (rd_count_q == '0))
            err_d = 1'b1;

        shifted = io.bus_readdata >> {ent.off, 3'b000};
        rdv_d   = trk_pop;
        rtag_d  = rtag_q;
        rdata_d = rdata_q;
        if (trk_pop) begin
            rtag_d = ent.tag;
            case (ent.size)
                2'd0:    rdata_d = {{56{ent.sext & shifted[7]}},  shifted[7:0]};
                2'd1:    rdata_d = {{48{ent.sext & shifted[15]}}, shifted[15:0]};
                2'd2:    rdata_d = {{32{ent.sext & shifted[31]}}, shifted[31:0]};
                default: rdata_d = shifted;
            endcase
        end

        req_wptr_d  = req_wptr_q + RQW'(req_push);
        req_rptr_d  = req_rptr_q + RQW'(issue);
        req_count_d = req_count_q + (RQW+1)'(req_push) - (RQW+1)'(issue);
        trk_wptr_d  = trk_wptr_q + RDW'(trk_push);
        trk_rptr_d  = trk_rptr_q + RDW'(trk_pop);
        rd_count_d  = rd_count_q + (RDW+1)'(trk_push) - (RDW+1)'(trk_pop);
    end

    // Control and output registers; reset drops bus commands immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_wptr_q  <= '0;
            req_rptr_q  <= '0;
            req_count_q <= '0;
            trk_wptr_q  <= '0;
            trk_rptr_q  <= '0;
            rd_count_q  <= '0;
            bus_addr_q  <= '0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            cmd_trk_q   <= '0;
            rdv_q       <= 1'b0;
            rtag_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_wptr_q  <= req_wptr_d;
            req_rptr_q  <= req_rptr_d;
            req_count_q <= req_count_d;
            trk_wptr_q  <= trk_wptr_d;
            trk_rptr_q  <= trk_rptr_d;
            rd_count_q  <= rd_count_d;
            bus_addr_q  <= bus_addr_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            cmd_trk_q   <= cmd_trk_d;
            rdv_q       <= rdv_d;
            rtag_q      <= rtag_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // FIFO storage; validity is tracked by the counters, so no reset needed
    always_ff @(posedge clock) begin
        if (req_push)
            req_mem_q[req_wptr_q] <= req_in;
        if (trk_push)
            trk_mem_q[trk_wptr_q] <= cmd_trk_q;
    end

    assign io.me_ready         = (req_count_q != (RQW+1)'(REQ_DEPTH));
    assign io.me_readdatavalid = rdv_q;
    assign io.me_readdatatag   = rtag_q;
    assign io.me_readdata      = rdata_q;
    assign io.me_error         = err_q;
    assign io.bus_address      = bus_addr_q;
    assign io.bus_read         = bus_read_q;
    assign io.bus_write        = bus_write_q;
    assign io.bus_byteenable   = bus_be_q;
    assign io.bus_writedata    = bus_wdata_q;
endmodule
